// File: rtl/auth_pkg.sv
// Shared constants for the authentication responder: message types, error
// codes, header field widths and the one-hot FSM state encoding.
package auth_pkg;

  localparam int HDR_W   = 32;
  localparam int FIELD_W = 8;

  localparam logic [7:0] PROTO_VERSION   = 8'h01;
  localparam logic [7:0] MSG_GET_DIGESTS = 8'h81;
  localparam logic [7:0] MSG_GET_CERT    = 8'h82;
  localparam logic [7:0] MSG_CHALLENGE   = 8'h83;
  localparam logic [7:0] MSG_ERROR       = 8'h7F;

  localparam logic [7:0] ERR_INVALID_REQ = 8'h01;
  localparam logic [7:0] ERR_UNSUP_PROTO = 8'h02;
  localparam logic [7:0] ERR_BUSY        = 8'h03;
  localparam logic [7:0] ERR_UNSPECIFIED = 8'h04;

  localparam logic [15:0] ERR_WLENGTH = 16'd4;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_DECODE    = 5'b00010,
    ST_WAIT_HND  = 5'b00100,
    ST_BUILD_ERR = 5'b01000,
    ST_SEND      = 5'b10000
  } state_e;

  function automatic logic [HDR_W-1:0] err_header(input logic [7:0] code);
    return {PROTO_VERSION, MSG_ERROR, code, 8'h00};
  endfunction

endpackage

// File: rtl/auth_hdr_check.sv
// Combinational request-header validation: picks the highest-priority error
// code and derives the handler type/slot for accepted requests.
module auth_hdr_check
  import auth_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic                 busy_in,
  input  logic [7:0]           version,
  input  logic [7:0]           msg_type,
  input  logic [2:0]           param1_slot,
  input  logic [NUM_SLOTS-1:0] slot_populated,
  output logic                 err,
  output logic [7:0]           err_code,
  output logic [1:0]           hnd_type,
  output logic [2:0]           hnd_slot
);

  logic [7:0] pop_ext;
  logic       slot_bad;
  logic       type_ok;

  // Priority-ordered validation of the captured header.
  always_comb begin
    pop_ext = 8'h00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pop_ext[i] = slot_populated[i];
    end
    // Out-of-range slots read as unpopulated through the zero-extended vector.
    slot_bad = (int'(param1_slot) >= NUM_SLOTS) || !pop_ext[param1_slot];
    type_ok  = (msg_type == MSG_GET_DIGESTS) || (msg_type == MSG_GET_CERT) ||
               (msg_type == MSG_CHALLENGE);
    hnd_type = msg_type[1:0];
    if (msg_type == MSG_GET_DIGESTS) begin
      hnd_slot = 3'd0;
    end else begin
      hnd_slot = param1_slot;
    end
    err      = 1'b1;
    err_code = 8'h00;
    if (busy_in) begin
      err_code = ERR_BUSY;
    end else if (version != PROTO_VERSION) begin
      err_code = ERR_UNSUP_PROTO;
    end else if (!type_ok) begin
      err_code = ERR_INVALID_REQ;
    end else if ((msg_type != MSG_GET_DIGESTS) && slot_bad) begin
      err_code = ERR_INVALID_REQ;
    end else begin
      err = 1'b0;
    end
  end

endmodule

// File: rtl/auth_responder_mc.sv
// Authentication responder: accepts one request, validates it, forwards it to a
// handler or builds an error, then returns the response. AUTH_RESP_TIMEOUT_EN adds a handler watchdog.
module auth_responder_mc
  import auth_pkg::*;
#(
  parameter int MSG_LEN        = 512,
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MSG_LEN-1:0]   req_msg,
  input  logic [NUM_SLOTS-1:0] slot_populated,
  input  logic                 busy_in,
  output logic                 hnd_req,
  output logic [1:0]           hnd_type,
  output logic [2:0]           hnd_slot,
  output logic [MSG_LEN-1:0]   hnd_msg,
  input  logic                 hnd_ack,
  input  logic                 hnd_err,
  input  logic [31:0]          hnd_header,
  input  logic [MSG_LEN-33:0]  hnd_payload,
  input  logic [15:0]          hnd_wlength,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_header,
  output logic [MSG_LEN-33:0]  rsp_payload,
  output logic [15:0]          rsp_wlength
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                hnd_req_q, hnd_req_d;
  logic [1:0]          hnd_type_q, hnd_type_d;
  logic [2:0]          hnd_slot_q, hnd_slot_d;
  logic [MSG_LEN-1:0]  hnd_msg_q, hnd_msg_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_header_q, rsp_header_d;
  logic [MSG_LEN-33:0] rsp_payload_q, rsp_payload_d;
  logic [15:0]         rsp_wlength_q, rsp_wlength_d;
  logic [7:0]          err_code_q, err_code_d;

  logic       chk_err;
  logic [7:0] chk_code;
  logic [1:0] chk_type;
  logic [2:0] chk_slot;

`ifdef AUTH_RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  auth_hdr_check #(.NUM_SLOTS(NUM_SLOTS)) u_hdr_check (
    .busy_in       (busy_in),
    .version       (hnd_msg_q[MSG_LEN-1 -: FIELD_W]),
    .msg_type      (hnd_msg_q[MSG_LEN-FIELD_W-1 -: FIELD_W]),
    .param1_slot   (hnd_msg_q[MSG_LEN-2*FIELD_W-6 -: 3]),
    .slot_populated(slot_populated),
    .err           (chk_err),
    .err_code      (chk_code),
    .hnd_type      (chk_type),
    .hnd_slot      (chk_slot)
  );

  // Next-state and next-output computation for the responder FSM.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    hnd_req_d     = hnd_req_q;
    hnd_type_d    = hnd_type_q;
    hnd_slot_d    = hnd_slot_q;
    hnd_msg_d     = hnd_msg_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_header_d  = rsp_header_q;
    rsp_payload_d = rsp_payload_q;
    rsp_wlength_d = rsp_wlength_q;
    err_code_d    = err_code_q;
`ifdef AUTH_RESP_TIMEOUT_EN
    tmo_cnt_d     = {CNT_W{1'b0}};
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          hnd_msg_d   = req_msg;
          req_ready_d = 1'b0;
          state_d     = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (chk_err) begin
          err_code_d = chk_code;
          state_d    = ST_BUILD_ERR;
        end else begin
          hnd_req_d  = 1'b1;
          hnd_type_d = chk_type;
          hnd_slot_d = chk_slot;
          state_d    = ST_WAIT_HND;
        end
      end
      ST_WAIT_HND: begin
        // Handler error outranks a simultaneous ack; ack outranks the watchdog.
        if (hnd_err) begin
          hnd_req_d  = 1'b0;
          err_code_d = ERR_INVALID_REQ;
          state_d    = ST_BUILD_ERR;
        end else if (hnd_ack) begin
          hnd_req_d     = 1'b0;
          rsp_header_d  = hnd_header;
          rsp_payload_d = hnd_payload;
          rsp_wlength_d = hnd_wlength;
          rsp_valid_d   = 1'b1;
          state_d       = ST_SEND;
        end else begin
`ifdef AUTH_RESP_TIMEOUT_EN
          if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            hnd_req_d  = 1'b0;
            err_code_d = ERR_UNSPECIFIED;
            state_d    = ST_BUILD_ERR;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_WAIT_HND;
`endif
        end
      end
      ST_BUILD_ERR: begin
        rsp_header_d  = err_header(err_code_q);
        rsp_payload_d = {(MSG_LEN-32){1'b0}};
        rsp_wlength_d = ERR_WLENGTH;
        rsp_valid_d   = 1'b1;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        hnd_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      hnd_req_q     <= 1'b0;
      hnd_type_q    <= 2'd0;
      hnd_slot_q    <= 3'd0;
      hnd_msg_q     <= {MSG_LEN{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_header_q  <= 32'h0000_0000;
      rsp_payload_q <= {(MSG_LEN-32){1'b0}};
      rsp_wlength_q <= 16'd0;
      err_code_q    <= 8'h00;
`ifdef AUTH_RESP_TIMEOUT_EN
      tmo_cnt_q     <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      hnd_req_q     <= hnd_req_d;
      hnd_type_q    <= hnd_type_d;
      hnd_slot_q    <= hnd_slot_d;
      hnd_msg_q     <= hnd_msg_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_header_q  <= rsp_header_d;
      rsp_payload_q <= rsp_payload_d;
      rsp_wlength_q <= rsp_wlength_d;
      err_code_q    <= err_code_d;
`ifdef AUTH_RESP_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign hnd_req     = hnd_req_q;
  assign hnd_type    = hnd_type_q;
  assign hnd_slot    = hnd_slot_q;
  assign hnd_msg     = hnd_msg_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_header  = rsp_header_q;
  assign rsp_payload = rsp_payload_q;
  assign rsp_wlength = rsp_wlength_q;

endmodule

// File: tb/tb_auth_responder_mc.sv
// Self-checking bench for auth_responder_mc: directed scenarios followed by
// randomized transactions checked against a rule-level reference model.
module tb_auth_responder_mc;

  localparam int MSG_LEN = 128;
  localparam int NS      = 4;
  localparam int TMO     = 16;
  localparam int PW      = MSG_LEN - 32;
`ifdef AUTH_RESP_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [MSG_LEN-1:0] req_msg;
  logic [NS-1:0]      slot_populated;
  logic               busy_in;
  logic               hnd_req;
  logic [1:0]         hnd_type;
  logic [2:0]         hnd_slot;
  logic [MSG_LEN-1:0] hnd_msg;
  logic               hnd_ack;
  logic               hnd_err;
  logic [31:0]        hnd_header;
  logic [PW-1:0]      hnd_payload;
  logic [15:0]        hnd_wlength;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_header;
  logic [PW-1:0]      rsp_payload;
  logic [15:0]        rsp_wlength;

  int total = 0;
  int bad   = 0;

  auth_responder_mc #(.MSG_LEN(MSG_LEN), .NUM_SLOTS(NS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg),
    .slot_populated(slot_populated), .busy_in(busy_in),
    .hnd_req(hnd_req), .hnd_type(hnd_type), .hnd_slot(hnd_slot), .hnd_msg(hnd_msg),
    .hnd_ack(hnd_ack), .hnd_err(hnd_err), .hnd_header(hnd_header),
    .hnd_payload(hnd_payload), .hnd_wlength(hnd_wlength),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_header(rsp_header),
    .rsp_payload(rsp_payload), .rsp_wlength(rsp_wlength)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pw();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Reference rule: error code for a request, 0 when it should go to a handler.
  function automatic logic [7:0] model_code(input logic [31:0] hdr, input logic busy,
                                            input logic [NS-1:0] slots);
    int unsigned ver, typ, slot;
    logic [7:0] pop;
    ver  = hdr[31:24];
    typ  = hdr[23:16];
    slot = hdr[15:8] % 8;
    pop  = 8'(slots);
    if (busy) return 8'h03;
    if (ver != 1) return 8'h02;
    if (typ < 'h81 || typ > 'h83) return 8'h01;
    if (typ != 'h81 && (slot >= NS || pop[slot] == 1'b0)) return 8'h01;
    return 8'h00;
  endfunction

  task automatic run_txn(input logic [31:0] hdr, input logic busy, input logic [NS-1:0] slots,
                         input int ack_delay, input bit use_err, input int rsp_delay,
                         input logic [15:0] wlen);
    logic [MSG_LEN-1:0] msg;
    logic [7:0]         code;
    logic [31:0]        exp_hdr;
    logic [PW-1:0]      exp_pay;
    logic [15:0]        exp_wl;
    int unsigned        typ;
    bit                 done;
    bit                 err_path;
    int                 k;
    msg  = {hdr, rand_pw()};
    code = model_code(hdr, busy, slots);
    typ  = hdr[23:16];
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_msg = msg; busy_in = busy; slot_populated = slots;
    @(negedge clk);
    // Requests presented outside IDLE must be ignored.
    req_valid = 1'($urandom_range(0, 1)); req_msg = {$urandom, rand_pw()};
    check("req_ready_low", req_ready, 1'b0);
    check("hnd_req_decode", hnd_req, 1'b0);
    @(negedge clk);
    if (code != 8'h00) begin
      check("hnd_req_on_err", hnd_req, 1'b0);
      check("rsp_valid_build", rsp_valid, 1'b0);
      @(negedge clk);
      exp_hdr = {8'h01, 8'h7F, code, 8'h00}; exp_pay = '0; exp_wl = 16'd4;
    end else begin
      k = 0; done = 1'b0; err_path = 1'b0;
      exp_hdr = 32'h0; exp_pay = '0; exp_wl = 16'd0;
      while (!done && k < 200) begin
        check("hnd_req_wait", hnd_req, 1'b1);
        check("hnd_type", hnd_type, 2'(typ - 'h80));
        check("hnd_slot", hnd_slot, (typ == 'h81) ? 3'd0 : hdr[10:8]);
        check("hnd_msg", hnd_msg, msg);
        if (k == ack_delay) begin
          hnd_header = $urandom; hnd_payload = rand_pw(); hnd_wlength = wlen;
          hnd_err = use_err;
          hnd_ack = use_err ? 1'($urandom_range(0, 1)) : 1'b1;
          if (use_err) begin
            err_path = 1'b1;
            exp_hdr = 32'h017F_0100; exp_pay = '0; exp_wl = 16'd4;
          end else begin
            exp_hdr = hnd_header; exp_pay = hnd_payload; exp_wl = wlen;
          end
          @(negedge clk);
          hnd_ack = 1'b0; hnd_err = 1'b0;
          hnd_header = $urandom; hnd_payload = rand_pw(); hnd_wlength = 16'($urandom);
          done = 1'b1;
        end else if (TMO_EN && k == TMO - 1) begin
          @(negedge clk);
          err_path = 1'b1;
          exp_hdr = 32'h017F_0400; exp_pay = '0; exp_wl = 16'd4;
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
        k++;
      end
      check("hnd_req_drop", hnd_req, 1'b0);
      if (err_path) begin
        check("rsp_valid_build", rsp_valid, 1'b0);
        @(negedge clk);
      end
    end
    for (int i = 0; i < rsp_delay; i++) begin
      check("rsp_hold_valid", rsp_valid, 1'b1);
      check("rsp_hold_header", rsp_header, exp_hdr);
      check("rsp_hold_payload", rsp_payload, exp_pay);
      check("rsp_hold_wlength", rsp_wlength, exp_wl);
      @(negedge clk);
    end
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_header", rsp_header, exp_hdr);
    check("rsp_payload", rsp_payload, exp_pay);
    check("rsp_wlength", rsp_wlength, exp_wl);
    check("hnd_req_send", hnd_req, 1'b0);
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0; busy_in = 1'b0;
    check("rsp_valid_done", rsp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] ver, typ, p1;
    reset = 1'b1; req_valid = 1'b0; req_msg = '0; slot_populated = '0; busy_in = 1'b0;
    hnd_ack = 1'b0; hnd_err = 1'b0; hnd_header = 32'h0; hnd_payload = '0;
    hnd_wlength = 16'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_hnd_req", hnd_req, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_header", rsp_header, 32'h0);
    check("rst_rsp_payload", rsp_payload, '0);
    check("rst_rsp_wlength", rsp_wlength, 16'd0);
    check("rst_hnd_type", hnd_type, 2'd0);
    check("rst_hnd_slot", hnd_slot, 3'd0);
    check("rst_hnd_msg", hnd_msg, '0);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    run_txn(32'h0181_0000, 1'b0, 4'hF, 2, 1'b0, 0, 16'd260);
    run_txn(32'h0283_0000, 1'b0, 4'hF, 0, 1'b0, 0, 16'd0);
    run_txn(32'h0182_0500, 1'b0, 4'hF, 0, 1'b0, 0, 16'd0);
    run_txn(32'h0182_0200, 1'b0, 4'b1011, 0, 1'b0, 0, 16'd0);
    run_txn(32'h0182_0300, 1'b0, 4'b1000, 0, 1'b0, 1, 16'd77);
    run_txn(32'h0183_0100, 1'b1, 4'hF, 0, 1'b0, 5, 16'd0);
    run_txn(32'h0183_0100, 1'b0, 4'hF, 1, 1'b1, 2, 16'd9);
    run_txn(32'h0184_0000, 1'b0, 4'hF, 0, 1'b0, 0, 16'd0);
    run_txn(32'h0181_0000, 1'b0, 4'hF, 0, 1'b0, 0, 16'hFFFF);
    // Long handler wait: timeout when enabled, otherwise an indefinite wait then ack.
    run_txn(32'h0181_0000, 1'b0, 4'hF, TMO_EN ? TMO : 40, 1'b0, 0, 16'd33);
    run_txn(32'h0183_0000, 1'b0, 4'hF, TMO - 1, 1'b0, 0, 16'd44);

    // Reset while waiting on the handler.
    req_valid = 1'b1; req_msg = {32'h0181_0000, rand_pw()}; slot_populated = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_hnd_req_before", hnd_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_hnd_req", hnd_req, 1'b0);
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_req_ready", req_ready, 1'b1);
    check("mid_hnd_msg", hnd_msg, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_req_ready", req_ready, 1'b1);
    check("post_hnd_req", hnd_req, 1'b0);
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      ver = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
      case ($urandom_range(0, 4))
        0: typ = 8'h81;
        1: typ = 8'h82;
        2: typ = 8'h83;
        default: typ = 8'($urandom);
      endcase
      p1 = 8'($urandom);
      run_txn({ver, typ, p1, 8'($urandom)}, 1'($urandom_range(0, 7) == 0), 4'($urandom),
              ($urandom_range(0, 7) == 0) ? 18 : int'($urandom_range(0, 3)),
              1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
